// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// length-field width, byte-lane numbering and the lane insert helper.
package loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loaderState_t;

  // Place one byte into the given little-endian lane of a word.
  function automatic logic [WORD_W-1:0] insertByte(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] b
  );
    logic [WORD_W-1:0] result;
    result = word;
    case (lane)
      LANE_0:  result[7:0]   = b;
      LANE_1:  result[15:8]  = b;
      LANE_2:  result[23:16] = b;
      LANE_3:  result[31:24] = b;
      default: result        = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Collects accepted bytes into a 32-bit little-endian word. The completed
// word and its valid pulse are presented in the cycle the 4th byte arrives,
// so the caller can register the whole word on that same edge.
module byte_word_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  input  logic              byteValid,
  input  logic [BYTE_W-1:0] byteIn,
  output logic [WORD_W-1:0] word,
  output logic              wordValid
);

  logic [1:0]        lane_r;
  logic [WORD_W-1:0] word_r;
  logic [WORD_W-1:0] packedWord_s;

  // Merge the incoming byte into the partial word at the current lane.
  always_comb begin
    packedWord_s = insertByte(word_r, lane_r, byteIn);
    word         = packedWord_s;
    wordValid    = byteValid && (lane_r == LANE_3);
  end

  // Lane counter and partial-word storage; a full word restarts at lane 0.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lane_r <= LANE_0;
      word_r <= 32'h0000_0000;
    end else if (clear) begin
      lane_r <= LANE_0;
      word_r <= 32'h0000_0000;
    end else if (byteValid) begin
      lane_r <= lane_r + 2'd1;
      word_r <= (lane_r == LANE_3) ? 32'h0000_0000 : packedWord_s;
    end else begin
      lane_r <= lane_r;
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction memory and holds the
// core in reset until a complete, in-range image has been written.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(DEPTH_WORDS);

  loaderState_t      state_r;
  logic [LEN_W-1:0]  wordCount_r;
  logic [LEN_W-1:0]  index_r;

  logic              accept_s;
  logic              packClear_s;
  logic              packValid_s;
  logic [WORD_W-1:0] packWord_s;
  logic              wordValid_s;
  logic [LEN_W-1:0]  lenNext_s;
  logic [LEN_W-1:0]  indexNext_s;

  // Handshake qualification and values needed by the state register.
  always_comb begin
    accept_s    = byte_valid_i && byte_ready_o;
    packClear_s = (state_r != ST_DATA) && (state_r != ST_WRITE);
    packValid_s = accept_s && (state_r == ST_DATA);
    lenNext_s   = {byte_data_i, wordCount_r[7:0]};
    indexNext_s = index_r + 16'd1;
  end

  byte_word_packer u_packer (
    .clk       (clk_i),
    .rstN      (reset_i),
    .clear     (packClear_s),
    .byteValid (packValid_s),
    .byteIn    (byte_data_i),
    .word      (packWord_s),
    .wordValid (wordValid_s)
  );

  // Loader FSM; every output is a flop updated together with the state.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r      <= ST_IDLE;
      wordCount_r  <= {LEN_W{1'b0}};
      index_r      <= {LEN_W{1'b0}};
      byte_ready_o <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= {ADDR_W{1'b0}};
      imem_wdata_o <= 32'h0000_0000;
      core_reset_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      imem_we_o <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start_i) begin
            state_r      <= ST_LEN_LO;
            wordCount_r  <= {LEN_W{1'b0}};
            index_r      <= {LEN_W{1'b0}};
            byte_ready_o <= 1'b1;
            core_reset_o <= 1'b0;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (accept_s) begin
            wordCount_r <= {8'h00, byte_data_i};
            state_r     <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept_s) begin
            wordCount_r <= lenNext_s;
            index_r     <= {LEN_W{1'b0}};
            if (lenNext_s == 16'd0) begin
              state_r      <= ST_DONE;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              core_reset_o <= 1'b1;
            end else if (lenNext_s > MAX_WORDS) begin
              state_r      <= ST_ERROR;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              error_o      <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (wordValid_s) begin
            state_r      <= ST_WRITE;
            byte_ready_o <= 1'b0;
            imem_we_o    <= 1'b1;
            imem_addr_o  <= index_r[ADDR_W-1:0];
            imem_wdata_o <= packWord_s;
          end
        end
        ST_WRITE: begin
          index_r <= indexNext_s;
          if (indexNext_s == wordCount_r) begin
            state_r      <= ST_DONE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            core_reset_o <= 1'b1;
          end else begin
            state_r      <= ST_DATA;
            byte_ready_o <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          byte_ready_o <= 1'b0;
          core_reset_o <= 1'b0;
          busy_o       <= 1'b0;
          done_o       <= 1'b0;
          error_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte streams are built from
// random data, and expected memory writes and status come from a
// stream-level model (length field, words assembled arithmetically).
module tb_program_loader;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        load_start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        core_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  int total = 0;
  int bad = 0;
  bit hung = 1'b0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  logic [7:0]  stream[0:1100];

  program_loader #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_start_i (load_start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .core_reset_o (core_reset_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every memory write strobe, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (imem_we_o) begin
      wrAddrQ.push_back(32'(imem_addr_o));
      wrDataQ.push_back(imem_wdata_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int model_len();
    return int'(stream[0]) + 256 * int'(stream[1]);
  endfunction

  function automatic logic [31:0] model_word(input int i);
    return 32'(stream[2 + 4*i]) + 32'(stream[3 + 4*i]) * 32'd256 +
           32'(stream[4 + 4*i]) * 32'd65536 + 32'(stream[5 + 4*i]) * 32'd16777216;
  endfunction

  task automatic build_stream(input int lenField, input int nWords);
    stream[0] = 8'(lenField % 256);
    stream[1] = 8'(lenField / 256);
    for (int i = 0; i < 4 * nWords; i++) stream[2 + i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk_i);
    load_start_i = 1'b1;
    @(negedge clk_i);
    load_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    guard = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      byte_valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && guard < 64) begin
      @(negedge clk_i);
      guard++;
    end
    if (!byte_ready_o) begin
      hung = 1'b1;
      byte_valid_i = 1'b0;
    end else begin
      @(negedge clk_i);
    end
  endtask

  task automatic send_range(input int first, input int last, input bit gaps);
    for (int i = first; i < last && !hung; i++) send_byte(stream[i], gaps);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_end();
    int guard;
    guard = 0;
    while (!(done_o || error_o) && guard < 64) begin
      @(negedge clk_i);
      guard++;
    end
    if (!(done_o || error_o)) hung = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({byte_ready_o, imem_we_o, core_reset_o, busy_o, done_o, error_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {byte_ready_o, imem_we_o, core_reset_o, busy_o, done_o, error_o});
    end
    total++;
    if (imem_addr_o !== 8'h00 || imem_wdata_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus got addr=%h data=%h want 0/0", imem_addr_o, imem_wdata_o);
    end
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    total++;
    if ({byte_ready_o, core_reset_o, busy_o, done_o, error_o} !== 5'b0) begin
      bad++;
      $display("FAIL idle_flags got=%b want=00000",
               {byte_ready_o, core_reset_o, busy_o, done_o, error_o});
    end
  endtask

  task automatic test_basic();
    logic [7:0] fixed[0:9];
    fixed = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 10; i++) stream[i] = fixed[i];
    hung = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    total++;
    if ({core_reset_o, busy_o, byte_ready_o} !== 3'b011) begin
      bad++;
      $display("FAIL basic_start got=%b want=011", {core_reset_o, busy_o, byte_ready_o});
    end
    send_range(0, 10, 1'b1);
    wait_end();
    total++;
    if (hung) begin bad++; $display("FAIL basic_timeout got=hung want=complete"); end
    total++;
    if (wrAddrQ.size() !== 2 || wrAddrQ[0] !== 32'd0 || wrDataQ[0] !== 32'h0000_0013 ||
        wrAddrQ[1] !== 32'd1 || wrDataQ[1] !== 32'h0010_0093) begin
      bad++;
      $display("FAIL basic_writes got n=%0d want 2 writes 0:00000013 1:00100093", wrAddrQ.size());
    end
    total++;
    if ({done_o, core_reset_o, busy_o, error_o} !== 4'b1100) begin
      bad++;
      $display("FAIL basic_status got=%b want=1100", {done_o, core_reset_o, busy_o, error_o});
    end
  endtask

  task automatic test_zero_len();
    build_stream(0, 0);
    hung = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    total++;
    if (core_reset_o !== 1'b0) begin
      bad++; $display("FAIL zero_core_drop got=%b want=0", core_reset_o);
    end
    send_range(0, 2, 1'b0);
    wait_end();
    repeat (2) @(negedge clk_i);
    total++;
    if (hung || wrAddrQ.size() !== 0 || {done_o, core_reset_o, error_o} !== 3'b110) begin
      bad++;
      $display("FAIL zero_len got hung=%0d writes=%0d status=%b want 0/0/110",
               hung, wrAddrQ.size(), {done_o, core_reset_o, error_o});
    end
  endtask

  task automatic test_too_long();
    build_stream(16'h0101, 0);
    hung = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    send_range(0, 2, 1'b1);
    wait_end();
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h5a;
    repeat (4) @(negedge clk_i);
    total++;
    if (hung || wrAddrQ.size() !== 0 ||
        {error_o, done_o, core_reset_o, busy_o, byte_ready_o} !== 5'b10000) begin
      bad++;
      $display("FAIL too_long got hung=%0d writes=%0d status=%b want 0/0/10000",
               hung, wrAddrQ.size(), {error_o, done_o, core_reset_o, busy_o, byte_ready_o});
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_full_depth();
    int n;
    build_stream(256, 256);
    n = model_len();
    hung = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    total++;
    if ({error_o, busy_o} !== 2'b01) begin
      bad++; $display("FAIL full_leave_error got=%b want=01", {error_o, busy_o});
    end
    send_range(0, 2 + 4 * n, 1'b1);
    wait_end();
    total++;
    if (hung || wrAddrQ.size() !== n || {done_o, core_reset_o} !== 2'b11) begin
      bad++;
      $display("FAIL full_depth got hung=%0d writes=%0d status=%b want 0/%0d/11",
               hung, wrAddrQ.size(), {done_o, core_reset_o}, n);
    end
    for (int i = 0; i < n && i < wrAddrQ.size(); i++) begin
      total++;
      if (wrAddrQ[i] !== 32'(i) || wrDataQ[i] !== model_word(i)) begin
        bad++;
        $display("FAIL full_word%0d got %h:%h want %h:%h", i, wrAddrQ[i], wrDataQ[i], i, model_word(i));
      end
    end
  endtask

  task automatic test_stall();
    int k;
    int weCyc;
    int xfer[0:15];
    build_stream(2, 2);
    wrAddrQ.delete(); wrDataQ.delete();
    hung = 1'b0;
    k = 0;
    weCyc = -1;
    pulse_start();
    byte_valid_i = 1'b1;
    byte_data_i  = stream[0];
    for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
      if (imem_we_o && weCyc < 0) begin
        weCyc = cyc;
        total++;
        if (byte_ready_o !== 1'b0) begin
          bad++; $display("FAIL stall_ready_in_write got=%b want=0", byte_ready_o);
        end
      end
      if (byte_ready_o) begin
        xfer[k] = cyc;
        k++;
      end
      @(negedge clk_i);
      if (k < 10) byte_data_i = stream[k];
    end
    byte_valid_i = 1'b0;
    total++;
    if (k !== 10) begin
      bad++; $display("FAIL stall_count got=%0d want=10", k);
    end else begin
      total++;
      if (xfer[5] !== xfer[0] + 5) begin
        bad++; $display("FAIL stall_back_to_back got=%0d want=%0d", xfer[5], xfer[0] + 5);
      end
      total++;
      if (weCyc !== xfer[5] + 1) begin
        bad++; $display("FAIL stall_we_cycle got=%0d want=%0d", weCyc, xfer[5] + 1);
      end
      total++;
      if (xfer[6] !== xfer[5] + 2) begin
        bad++; $display("FAIL stall_fifth_byte got=%0d want=%0d", xfer[6], xfer[5] + 2);
      end
    end
    wait_end();
    total++;
    if (hung || wrAddrQ.size() !== 2 || wrDataQ[0] !== model_word(0) || wrDataQ[1] !== model_word(1)) begin
      bad++;
      $display("FAIL stall_writes got n=%0d want 2 words %h %h", wrAddrQ.size(), model_word(0), model_word(1));
    end
  endtask

  task automatic test_reset_midload();
    build_stream(3, 3);
    hung = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    send_range(0, 8, 1'b1);
    #2;
    reset_i = 1'b0;
    #1;
    total++;
    if ({byte_ready_o, imem_we_o, core_reset_o, busy_o, done_o, error_o} !== 6'b0 ||
        imem_addr_o !== 8'h00 || imem_wdata_o !== 32'h0) begin
      bad++;
      $display("FAIL async_reset got flags=%b addr=%h data=%h want 0",
               {byte_ready_o, imem_we_o, core_reset_o, busy_o, done_o, error_o}, imem_addr_o, imem_wdata_o);
    end
    repeat (4) @(negedge clk_i);
    total++;
    if (hung || wrAddrQ.size() !== 1 || wrDataQ[0] !== model_word(0)) begin
      bad++;
      $display("FAIL abort_writes got n=%0d want 1 word %h", wrAddrQ.size(), model_word(0));
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    build_stream(2, 2);
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    send_range(0, 10, 1'b1);
    wait_end();
    total++;
    if (hung || wrAddrQ.size() !== 2 || wrDataQ[0] !== model_word(0) ||
        wrDataQ[1] !== model_word(1) || {done_o, core_reset_o} !== 2'b11) begin
      bad++;
      $display("FAIL post_reset_load got n=%0d status=%b want 2/11", wrAddrQ.size(), {done_o, core_reset_o});
    end
  endtask

  task automatic test_restart();
    build_stream(3, 3);
    hung = 1'b0;
    wrAddrQ.delete(); wrDataQ.delete();
    pulse_start();
    total++;
    if ({core_reset_o, done_o, busy_o} !== 3'b001) begin
      bad++; $display("FAIL restart_drop got=%b want=001", {core_reset_o, done_o, busy_o});
    end
    send_range(0, 7, 1'b0);
    pulse_start();
    @(negedge clk_i);
    total++;
    if ({busy_o, byte_ready_o, done_o} !== 3'b110) begin
      bad++; $display("FAIL ignored_start got=%b want=110", {busy_o, byte_ready_o, done_o});
    end
    send_range(7, 14, 1'b1);
    wait_end();
    total++;
    if (hung || wrAddrQ.size() !== 3 || {done_o, core_reset_o} !== 2'b11) begin
      bad++;
      $display("FAIL restart_count got n=%0d status=%b want 3/11", wrAddrQ.size(), {done_o, core_reset_o});
    end
    for (int i = 0; i < 3 && i < wrAddrQ.size(); i++) begin
      total++;
      if (wrAddrQ[i] !== 32'(i) || wrDataQ[i] !== model_word(i)) begin
        bad++;
        $display("FAIL restart_word%0d got %h:%h want %h:%h", i, wrAddrQ[i], wrDataQ[i], i, model_word(i));
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      build_stream(n, n);
      hung = 1'b0;
      wrAddrQ.delete(); wrDataQ.delete();
      pulse_start();
      total++;
      if (core_reset_o !== 1'b0) begin
        bad++; $display("FAIL rand%0d_core_drop got=%b want=0", it, core_reset_o);
      end
      send_range(0, 2 + 4 * model_len(), 1'b1);
      wait_end();
      total++;
      if (hung || wrAddrQ.size() !== model_len() || {done_o, error_o, core_reset_o} !== 3'b101) begin
        bad++;
        $display("FAIL rand%0d_end got n=%0d status=%b want %0d/101",
                 it, wrAddrQ.size(), {done_o, error_o, core_reset_o}, model_len());
      end
      for (int i = 0; i < n && i < wrAddrQ.size(); i++) begin
        total++;
        if (wrAddrQ[i] !== 32'(i) || wrDataQ[i] !== model_word(i)) begin
          bad++;
          $display("FAIL rand%0d_word%0d got %h:%h want %h:%h",
                   it, i, wrAddrQ[i], wrDataQ[i], i, model_word(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_too_long();
    test_stall();
    test_restart();
    test_reset_midload();
    test_random();
    test_full_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: DEPTH_WORDS, 256, instruction-memory capacity in 32-bit words.
REQ-002 Parameter: ADDR_W, 8, width of the word address (clog2 of DEPTH_WORDS).
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 load_start_i  in  1  single-cycle request to begin a load.
REQ-006 byte_valid_i  in  1  the upstream byte on byte_data_i is valid.
REQ-007 byte_data_i  in  8  program-stream byte.
REQ-008 byte_ready_o  out  1  loader accepts a byte this cycle.
REQ-009 imem_we_o  out  1  instruction-memory write strobe.
REQ-010 imem_addr_o  out  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata_o  out  32  instruction word to write.
REQ-012 core_reset_o  out  1  active-low reset to the pipelined core; low holds the core in reset.
REQ-013 busy_o, done_o, error_o  out  1 each  status flags.

Function
REQ-014 A byte SHALL transfer only in a cycle where byte_valid_i and byte_ready_o are both high.
REQ-015 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERROR.
REQ-016 load_start_i SHALL move IDLE, DONE or ERROR to LEN_LO, and SHALL be ignored in all other states.
REQ-017 byte_ready_o SHALL be high only in LEN_LO, LEN_HI and DATA.
REQ-018 LEN_LO and LEN_HI SHALL each capture one byte into a 16-bit word count N, little-endian.
REQ-019 On leaving LEN_HI: N==0 goes to DONE; N>DEPTH_WORDS goes to ERROR; otherwise go to DATA with word index 0.
REQ-020 DATA SHALL pack 4 accepted bytes little-endian into one word, with the first byte in bits 7:0.
REQ-021 After the 4th byte, DATA SHALL go to WRITE.
REQ-022 WRITE lasts exactly one cycle, with imem_we_o=1, imem_addr_o=index and imem_wdata_o=packed word.
REQ-023 imem_we_o SHALL therefore assert in the cycle after the 4th byte is accepted.
REQ-024 After WRITE, index SHALL increment; if index equals N go to DONE, otherwise return to DATA.
REQ-025 imem_we_o SHALL be 0 in every state except WRITE.
REQ-026 No byte SHALL be accepted in WRITE, so bytes held valid by the upstream stall one cycle.
REQ-027 core_reset_o SHALL be driven from a flop and be high only while in DONE.
REQ-028 core_reset_o SHALL go low in the same cycle LEN_LO is entered from DONE.
REQ-029 busy_o SHALL be high in LEN_LO, LEN_HI, DATA and WRITE.
REQ-030 done_o SHALL be high in DONE, and error_o SHALL be high in ERROR.
REQ-031 ERROR SHALL hold the core in reset until a new load_start_i is received.
REQ-032 Gaps in byte_valid_i SHALL stall the FSM with no timeout.

Reset
REQ-033 While reset_i is low: state=IDLE, core_reset_o=0, byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, N=0, index=0, busy_o=done_o=error_o=0.
REQ-034 Reset asserted mid-load SHALL abort the load immediately; any words already written remain in memory and no further writes occur.

Structure
REQ-035 A shared package loader_pkg SHALL hold the state enum, LEN_W=16 and the byte-lane constants.
REQ-036 Byte packing SHALL be a sub-module byte_word_packer, with byte in, a 2-bit lane counter, word_valid pulse and clear.

Verification
REQ-037 Stream 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013 and addr1=0x00100093, then done_o=1 and core_reset_o=1.
REQ-038 Stream 00 00 -> DONE with no imem_we_o pulse and core_reset_o=1.
REQ-039 Length 0x0101 with DEPTH_WORDS=256 -> ERROR, error_o=1, core_reset_o=0, no writes.
REQ-040 byte_valid_i held high through one word -> byte_ready_o=0 in the WRITE cycle, and the 5th byte is accepted the cycle after.
REQ-041 reset_i pulled low after 6 data bytes -> all outputs reach their reset values asynchronously, and a fresh load then succeeds.
REQ-042 load_start_i pulsed during DATA -> ignored; a second load_start_i from DONE drops core_reset_o to 0 and reloads.
